psram_responder: RTL and testbench
==================================

// Module: psram_responder
// PURPOSE
//  Cycle-sampled responder model of the async-mode cellular RAM on the ram_* bus.
//  It answers the memory controller's read and write strobes from an internal 16-bit word array.
//  It is used as the far-end device in controller benches and as an on-chip loopback target.
//  All bus inputs are sampled on clk; ram_clk is unused in async mode.
// PARAMETERS
//  ADDR_W    10  word-address bits implemented; ram_addr[25:ADDR_W] ignored (aliasing)
//  READ_LAT  4   clk cycles from read detect to valid data (min 1)
//  WR_MIN    2   min cycles ce&we held low for a write to commit (min 1)
// PORTS
//  clk       in     1   system clock
//  rst       in     1   synchronous reset, active-high
//  ram_addr  in     26  word address
//  ram_data  inout  16  data bus; driven only in RD_DATA, else Z
//  ram_oe    in     1   output enable, active-low
//  ram_we    in     1   write enable, active-low
//  ram_clk   in     1   unused (async mode)
//  ram_adv   in     1   address valid, active-low; address latched each cycle it is low
//  ram_wait  out    1   busy, active-high, during read latency
//  ram_ce    in     1   chip enable, active-low
//  ram_ub    in     1   upper byte enable, active-low
//  ram_lb    in     1   lower byte enable, active-low
//  ram_cre   in     1   config register enable, active-high
//  err_viol  out    1   1-cycle pulse on protocol violation
// BEHAVIOUR
//  - Inputs are registered once; all decisions use the registered copy (1-cycle input skew).
//  - Reset: state=IDLE, ram_wait=0, err_viol=0, bus Z, addr_q=0. Memory contents are NOT cleared.
//  - Reset mid-access: the access is abandoned; a pending write is discarded; the bus is released next cycle.
//  - addr_q <= ram_addr[ADDR_W-1:0] every cycle adv=0; it holds while adv=1.
//  - IDLE: ce=0,we=0 -> WR_ACT (cnt=1). ce=0,oe=0,we=1,cre=0 -> RD_WAIT (cnt=1, ram_wait=1).
//  - RD_WAIT: cnt counts up. At cnt==READ_LAT -> RD_DATA, ram_wait=0.
//    ce=1 or oe=1 in RD_WAIT -> IDLE, ram_wait=0, no drive.
//  - RD_DATA: ram_data = mem[addr_q]. Byte lane with ub/lb=1 drives 8'h00.
//    An addr_q change updates data 1 cycle later, with no new latency.
//    ce=1 or oe=1 -> IDLE; bus Z the following cycle.
//    we=0 while in RD_DATA -> err_viol pulse and release the bus, then WR_ACT.
//  - WR_ACT: data_q<=ram_data, be_q<=~{ub,lb} every cycle; cnt saturates at WR_MIN.
//    we=1 or ce=1 -> WR_COMMIT if cnt>=WR_MIN; otherwise IDLE with err_viol pulse (write dropped).
//  - WR_COMMIT (1 cycle): write mem[addr_q] with byte enables be_q, then IDLE.
//    A read that starts next cycle sees the new data.
//  - oe=0 and we=0 together with ce=0: the write takes priority; err_viol pulses once on entry.
//  - Counters are $clog2(max(READ_LAT,WR_MIN))+1 bits and saturate; they never wrap.
// CONFIGURATION
//  PSRAM_BCR_EN defined:
//    - Access with cre=1, ce=0, we=0 commits ram_addr[15:0] into a bus config register bcr (reset 16'h9D1F).
//    - Memory is not written.
//    - A read with cre=1 returns bcr after READ_LAT.
//  PSRAM_BCR_EN undefined:
//    - cre is ignored.
//    - An access with cre=1 behaves as a normal array access.
// TESTING
//  1. rst 1 cycle -> ram_data Z, ram_wait=0, err_viol=0, state IDLE.
//  2. Write 16'hA55A @addr 3 (ce=0, we=0, 3 cycles) then read @3 -> ram_wait=1 for 4 cycles;
//     ram_data=16'hA55A from cycle 5.
//  3. Write 16'h1234 @7 with ub=1, lb=0 over 16'hFFFF -> readback 16'hFF34;
//     a read with ub=1 returns 16'h0034.
//  4. we low for 1 cycle (WR_MIN=2) with 16'hBEEF @5 -> err_viol pulses once; mem[5] unchanged.
//  5. Address 1027 (ADDR_W=10) reads the same word as 3.
//     Dropping oe at latency cycle 2 -> no drive, back to IDLE.
//  6. PSRAM_BCR_EN: cre=1 write with addr 16'h0010, then cre=1 read -> 16'h0010;
//     array word 16 unchanged.

Source files
------------

// File: rtl/psram_responder.sv
// Cycle-sampled responder for the async-mode cellular RAM bus, backed by a 16-bit word array.
// Optional feature: define PSRAM_BCR_EN to add the cre-addressed bus configuration register.
module psram_responder #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 4,
  parameter int WR_MIN   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [25:0] ram_addr,
  inout  wire  [15:0] ram_data,
  input  logic        ram_oe,
  input  logic        ram_we,
  input  logic        ram_clk,
  input  logic        ram_adv,
  output logic        ram_wait,
  input  logic        ram_ce,
  input  logic        ram_ub,
  input  logic        ram_lb,
  input  logic        ram_cre,
  output logic        err_viol
);
  localparam int MAX_CNT = (READ_LAT > WR_MIN) ? READ_LAT : WR_MIN;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] WR_SAT  = CNT_W'(WR_MIN);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_ACT, WR_COMMIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              cre_acc_q, cre_acc_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [1:0]        be_q, be_d;

  logic              ce_q, we_q, oe_q, ub_q, lb_q, cre_q;
  logic [15:0]       din_q;
  logic [ADDR_W-1:0] addr_q;

  logic              cre_hit;
  logic [15:0]       cfg_src;
  logic [15:0]       bcr_word;
  logic [15:0]       rdata_q;
  logic [15:0]       rd_word;
  logic [15:0]       lane_word;
  logic              drive;

  // Single input sampling stage; every decision below looks only at these copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q   <= 1'b1;
      we_q   <= 1'b1;
      oe_q   <= 1'b1;
      ub_q   <= 1'b1;
      lb_q   <= 1'b1;
      cre_q  <= 1'b0;
      din_q  <= '0;
      addr_q <= '0;
    end else begin
      ce_q   <= ram_ce;
      we_q   <= ram_we;
      oe_q   <= ram_oe;
      ub_q   <= ram_ub;
      lb_q   <= ram_lb;
      cre_q  <= ram_cre;
      din_q  <= ram_data;
      if (!ram_adv) addr_q <= ram_addr[ADDR_W-1:0];
    end
  end

`ifdef PSRAM_BCR_EN
  logic [15:0] bcr_q;
  logic [15:0] bcr_src_q;

  assign cre_hit  = cre_q;
  assign cfg_src  = bcr_src_q;
  assign bcr_word = bcr_q;

  // A config write carries its payload on the address bus, not the data bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcr_q     <= 16'h9D1F;
      bcr_src_q <= '0;
    end else begin
      if (!ram_adv) bcr_src_q <= ram_addr[15:0];
      if (state_q == WR_COMMIT && cre_acc_q) bcr_q <= wdata_q;
    end
  end
`else
  logic unused_cre;

  assign unused_cre = cre_q;
  assign cre_hit    = 1'b0;
  assign cfg_src    = '0;
  assign bcr_word   = '0;
`endif

  logic unused_bus;
  assign unused_bus = ^{ram_clk, ram_addr[25:ADDR_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      cre_acc_q <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      cre_acc_q <= cre_acc_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    cre_acc_d = cre_acc_q;
    case (state_q)
      IDLE: begin
        // Write wins over a simultaneous read strobe, flagged as a violation.
        if (!ce_q && !we_q) begin
          state_d   = WR_ACT;
          cnt_d     = CNT_ONE;
          err_d     = !oe_q;
          cre_acc_d = cre_hit;
        end else if (!ce_q && !oe_q) begin
          state_d   = RD_WAIT;
          cnt_d     = CNT_ONE;
          cre_acc_d = cre_hit;
        end
      end
      RD_WAIT, RD_DATA: begin
        if (ce_q) begin
          state_d = IDLE;
        end else if (!we_q) begin
          state_d   = WR_ACT;
          cnt_d     = CNT_ONE;
          err_d     = 1'b1;
          cre_acc_d = cre_hit;
        end else if (oe_q) begin
          state_d = IDLE;
        end else if (state_q == RD_WAIT) begin
          if (cnt_q >= RD_LAST) state_d = RD_DATA;
          else                  cnt_d   = cnt_q + CNT_ONE;
        end
      end
      WR_ACT: begin
        if (ce_q || we_q) begin
          if (cnt_q >= WR_SAT) begin
            state_d = WR_COMMIT;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (cnt_q < WR_SAT) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WR_COMMIT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Write payload tracks the bus for every cycle the strobe is held.
  always_comb begin
    wdata_d = wdata_q;
    be_d    = be_q;
    if (state_d == WR_ACT) begin
      wdata_d = cre_acc_d ? cfg_src : din_q;
      be_d    = ~{ub_q, lb_q};
    end
  end

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && state_q == WR_COMMIT && !cre_acc_q) begin
      if (be_q[0]) mem[addr_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem[addr_q][15:8] <= wdata_q[15:8];
    end
    rdata_q <= mem[addr_q];
  end

  always_comb begin
    rd_word   = cre_acc_q ? bcr_word : rdata_q;
    lane_word = {ub_q ? 8'h00 : rd_word[15:8], lb_q ? 8'h00 : rd_word[7:0]};
    drive     = (state_q == RD_DATA);
    ram_wait  = (state_q == RD_WAIT);
    err_viol  = err_q;
  end

  assign ram_data = drive ? lane_word : 16'hzzzz;

endmodule

// File: tb/tb_psram_responder.sv
// Directed bench for psram_responder: vector table of bus transactions plus multi-cycle corner sequences.
module tb_psram_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_oe, ram_we, ram_clk, ram_adv, ram_wait;
  logic        ram_ce, ram_ub, ram_lb, ram_cre, err_viol;
  logic        tb_drv;
  logic [15:0] tb_wd;
  int          checks = 0;
  int          errors = 0;
  int          err_seen = 0;
  int          e0;
  int          bad;

  typedef struct {
    bit          is_wr;
    logic [25:0] addr;
    logic [15:0] data;
    bit          ub;
    bit          lb;
    bit          cre;
    int          hold;
    logic [15:0] exp;
    int          exp_err;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  assign ram_data = tb_drv ? tb_wd : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (ram_data[i]);
  end

  always @(negedge clk) if (err_viol === 1'b1) err_seen++;

  psram_responder dut (
    .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_oe(ram_oe), .ram_we(ram_we), .ram_clk(ram_clk), .ram_adv(ram_adv),
    .ram_wait(ram_wait), .ram_ce(ram_ce), .ram_ub(ram_ub), .ram_lb(ram_lb),
    .ram_cre(ram_cre), .err_viol(err_viol)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [25:0] a, input logic [15:0] d, input bit ub, input bit lb,
                          input bit cre, input int hold, input bit oe_low);
    @(negedge clk);
    ram_addr = a; ram_ub = ub; ram_lb = lb; ram_cre = cre;
    tb_wd = d; tb_drv = 1'b1; ram_ce = 1'b0; ram_we = 1'b0; ram_oe = !oe_low;
    repeat (hold) @(negedge clk);
    ram_ce = 1'b1; ram_we = 1'b1; ram_oe = 1'b1; tb_drv = 1'b0;
    ram_ub = 1'b0; ram_lb = 1'b0; ram_cre = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_read(input string nm, input logic [25:0] a, input bit ub, input bit lb,
                         input bit cre, input logic [15:0] exp);
    logic [5:0] wv;
    @(negedge clk);
    ram_addr = a; ram_ub = ub; ram_lb = lb; ram_cre = cre; ram_ce = 1'b0; ram_oe = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wv[5-i] = ram_wait;
    end
    check({nm, "_wait"}, 32'(wv), 32'(6'b011110));
    check({nm, "_data"}, 32'(ram_data), 32'(exp));
    ram_ce = 1'b1; ram_oe = 1'b1; ram_ub = 1'b0; ram_lb = 1'b0; ram_cre = 1'b0;
    repeat (2) @(negedge clk);
    check({nm, "_rel"}, 32'(ram_data), 32'hFFFF);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 26'd3,    16'hA55A, 1'b0, 1'b0, 1'b0, 3, 16'h0000, 0};
    vecs[1]  = '{1'b0, 26'd3,    16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'hA55A, 0};
    vecs[2]  = '{1'b1, 26'd7,    16'hFFFF, 1'b0, 1'b0, 1'b0, 2, 16'h0000, 0};
    vecs[3]  = '{1'b1, 26'd7,    16'h1234, 1'b1, 1'b0, 1'b0, 3, 16'h0000, 0};
    vecs[4]  = '{1'b0, 26'd7,    16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'hFF34, 0};
    vecs[5]  = '{1'b0, 26'd7,    16'h0000, 1'b1, 1'b0, 1'b0, 0, 16'h0034, 0};
    vecs[6]  = '{1'b0, 26'd7,    16'h0000, 1'b0, 1'b1, 1'b0, 0, 16'hFF00, 0};
    vecs[7]  = '{1'b1, 26'd5,    16'h0505, 1'b0, 1'b0, 1'b0, 2, 16'h0000, 0};
    vecs[8]  = '{1'b1, 26'd5,    16'hBEEF, 1'b0, 1'b0, 1'b0, 1, 16'h0000, 1};
    vecs[9]  = '{1'b0, 26'd5,    16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'h0505, 0};
    vecs[10] = '{1'b0, 26'd1027, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'hA55A, 0};
    vecs[11] = '{1'b1, 26'd9,    16'h1111, 1'b0, 1'b0, 1'b0, 5, 16'h0000, 0};
    vecs[12] = '{1'b0, 26'd9,    16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'h1111, 0};

    rst = 1'b1; ram_addr = '0; ram_oe = 1'b1; ram_we = 1'b1; ram_clk = 1'b0; ram_adv = 1'b0;
    ram_ce = 1'b1; ram_ub = 1'b0; ram_lb = 1'b0; ram_cre = 1'b0; tb_drv = 1'b0; tb_wd = '0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_wait", 32'(ram_wait), 32'(1'b0));
    check("rst_err",  32'(err_viol), 32'(1'b0));
    check("rst_bus",  32'(ram_data), 32'hFFFF);

    for (int i = 0; i < NV; i++) begin
      e0 = err_seen;
      if (vecs[i].is_wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].ub, vecs[i].lb, vecs[i].cre, vecs[i].hold, 1'b0);
      else
        do_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].ub, vecs[i].lb, vecs[i].cre, vecs[i].exp);
      check($sformatf("v%0d_err", i), 32'(err_seen - e0), 32'(vecs[i].exp_err));
    end

    // read abandoned by oe rising during latency
    @(negedge clk); ram_addr = 26'd3; ram_ce = 1'b0; ram_oe = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_wait_hi", 32'(ram_wait), 32'(1'b1));
    @(negedge clk); ram_oe = 1'b1;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ram_wait !== 1'b0 || ram_data !== 16'hFFFF) bad++;
    end
    check("abort_nodrive", 32'(bad), 32'd0);
    ram_ce = 1'b1;
    repeat (2) @(negedge clk);

    // oe and we low together: write wins, one violation pulse
    e0 = err_seen;
    do_write(26'd11, 16'hC0DE, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    check("coll_err", 32'(err_seen - e0), 32'd1);
    do_read("coll_rd", 26'd11, 1'b0, 1'b0, 1'b0, 16'hC0DE);

    // we falls while data is being driven
    e0 = err_seen;
    @(negedge clk); ram_addr = 26'd3; ram_ce = 1'b0; ram_oe = 1'b0;
    repeat (6) @(negedge clk);
    check("rdwr_drive", 32'(ram_data), 32'hA55A);
    ram_we = 1'b0;
    repeat (2) @(negedge clk);
    check("rdwr_release", 32'(ram_data), 32'hFFFF);
    tb_wd = 16'h3C3C; tb_drv = 1'b1;
    repeat (3) @(negedge clk);
    ram_we = 1'b1; ram_ce = 1'b1; ram_oe = 1'b1; tb_drv = 1'b0;
    repeat (4) @(negedge clk);
    check("rdwr_err", 32'(err_seen - e0), 32'd1);
    do_read("rdwr_rd", 26'd3, 1'b0, 1'b0, 1'b0, 16'h3C3C);

    // reset during an active write discards it
    e0 = err_seen;
    @(negedge clk); ram_addr = 26'd9; tb_wd = 16'h7777; tb_drv = 1'b1; ram_ce = 1'b0; ram_we = 1'b0;
    repeat (2) @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; ram_ce = 1'b1; ram_we = 1'b1; tb_drv = 1'b0;
    repeat (4) @(negedge clk);
    check("rstwr_err", 32'(err_seen - e0), 32'd0);
    do_read("rstwr_rd", 26'd9, 1'b0, 1'b0, 1'b0, 16'h1111);

    // reset while driving releases the bus next cycle
    @(negedge clk); ram_addr = 26'd7; ram_ce = 1'b0; ram_oe = 1'b0;
    repeat (6) @(negedge clk);
    check("rstrd_drive", 32'(ram_data), 32'hFF34);
    rst = 1'b1; ram_ce = 1'b1; ram_oe = 1'b1;
    @(negedge clk);
    check("rstrd_bus",  32'(ram_data), 32'hFFFF);
    check("rstrd_wait", 32'(ram_wait), 32'(1'b0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef PSRAM_BCR_EN
    do_write(26'd16, 16'h1616, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    do_read("bcr_rst", 26'd16, 1'b0, 1'b0, 1'b1, 16'h9D1F);
    e0 = err_seen;
    do_write(26'h0010, 16'hDEAD, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    check("bcr_wr_err", 32'(err_seen - e0), 32'd0);
    do_read("bcr_rd",  26'd16, 1'b0, 1'b0, 1'b1, 16'h0010);
    do_read("bcr_arr", 26'd16, 1'b0, 1'b0, 1'b0, 16'h1616);
`else
    do_write(26'd16, 16'h1616, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    do_write(26'd16, 16'h0BAD, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    do_read("cre_arr", 26'd16, 1'b0, 1'b0, 1'b0, 16'h0BAD);
    do_read("cre_rd",  26'd16, 1'b0, 1'b0, 1'b1, 16'h0BAD);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
